// File: rtl/mojo_serial_block_queue_out_pkg.sv
// Shared types and helpers for the Mojo block serializer.
// Holds the FSM state enum, the length clamp and the tx_len width helper.
package mojo_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

    function automatic int len_bits(input int block_bytes);
        return $clog2(block_bytes + 1);
    endfunction

    // Zero or oversize lengths mean "the whole block".
    function automatic int clamp_len(input int len, input int block_bytes);
        if (len == 0 || len > block_bytes) begin
            return block_bytes;
        end
        return len;
    endfunction

endpackage

// File: rtl/mojo_serial_block_queue_out_if.sv
// Block-side and UART-side handshake bundle of the block serializer.
// The master is the block producer / UART; the slave is the serializer.
interface mojo_serial_block_queue_out_if #(
    parameter int BLOCK_BYTES = 4,
    parameter int LEN_BITS    = mojo_serial_pkg::len_bits(BLOCK_BYTES)
);
    logic                     tx_busy;
    logic [7:0]               tx_data;
    logic                     new_tx_data;
    logic [BLOCK_BYTES*8-1:0] tx_block;
    logic [LEN_BITS-1:0]      tx_len;
    logic                     new_tx_block;
    logic                     tx_block_ready;
    logic                     tx_block_busy;
    logic                     tx_block_done;
    logic                     tx_block_dropped;

    modport master (
        output tx_busy, tx_block, tx_len, new_tx_block,
        input  tx_data, new_tx_data, tx_block_ready, tx_block_busy,
               tx_block_done, tx_block_dropped
    );

    modport slave (
        input  tx_busy, tx_block, tx_len, new_tx_block,
        output tx_data, new_tx_data, tx_block_ready, tx_block_busy,
               tx_block_done, tx_block_dropped
    );

endinterface

// File: rtl/mojo_serial_block_queue_out_fifo.sv
// Whole-block FIFO: DEPTH entries of WIDTH bits, pointers wrap modulo DEPTH.
// Pushes while full and pops while empty are ignored.
module mojo_block_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                do_push;
    logic                do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_BITS'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Explicit wrap keeps non-power-of-two depths inside the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mojo_serial_block_queue_out.sv
// Block serializer: queues whole blocks and feeds them byte by byte to serial_tx
// through its tx_busy / new_tx_data handshake.
module mojo_serial_block_queue_out
    import mojo_serial_pkg::*;
#(
    parameter int BLOCK_BYTES = 4,
    parameter int QUEUE_DEPTH = 2,
    parameter int MSB_FIRST   = 0,
    parameter int LEN_BITS    = len_bits(BLOCK_BYTES)
) (
    input logic                          clk,
    input logic                          rst_n,
    mojo_serial_block_queue_out_if.slave bus
);
    localparam int DATA_BITS  = BLOCK_BYTES * 8;
    localparam int ENTRY_BITS = DATA_BITS + LEN_BITS;

    state_t                state;
    state_t                state_next;
    logic [LEN_BITS-1:0]   eff_len;
    logic [ENTRY_BITS-1:0] fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  issue;
    logic                  advance;
    logic [DATA_BITS-1:0]  head_data;
    logic [LEN_BITS-1:0]   head_len;
    logic [DATA_BITS-1:0]  aligned;
    logic [7:0]            cur_byte;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [LEN_BITS-1:0]   remaining;
    logic [7:0]            data_reg;
    logic                  strobe_reg;
    logic                  done_reg;
    logic                  dropped_reg;

    assign eff_len = LEN_BITS'(clamp_len(int'(bus.tx_len), BLOCK_BYTES));

    mojo_block_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.new_tx_block),
        .wr_data ({eff_len, bus.tx_block}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_data = fifo_rd[DATA_BITS-1:0];
    assign head_len  = fifo_rd[ENTRY_BITS-1 -: LEN_BITS];

    // MSB-first blocks are pre-shifted so the highest valid byte sits at the top.
    always_comb begin
        aligned  = head_data;
        cur_byte = shift_reg[7:0];
        if (MSB_FIRST != 0) begin
            aligned  = head_data << (8 * (BLOCK_BYTES - int'(head_len)));
            cur_byte = shift_reg[DATA_BITS-1 -: 8];
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        issue      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    issue      = 1'b1;
                    state_next = HOLD;
                end
            end
            // HOLD skips the cycle where serial_tx has not yet raised tx_busy.
            HOLD: begin
                advance    = 1'b1;
                state_next = (remaining == LEN_BITS'(1)) ? IDLE : SEND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            remaining   <= '0;
            data_reg    <= '0;
            strobe_reg  <= 1'b0;
            done_reg    <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            state       <= state_next;
            strobe_reg  <= issue;
            done_reg    <= advance && (remaining == LEN_BITS'(1));
            dropped_reg <= bus.new_tx_block && fifo_full;
            if (issue) begin
                data_reg <= cur_byte;
            end
            if (fifo_pop) begin
                shift_reg <= aligned;
                remaining <= head_len;
            end else if (advance) begin
                shift_reg <= (MSB_FIRST != 0) ? (shift_reg << 8) : (shift_reg >> 8);
                remaining <= remaining - LEN_BITS'(1);
            end
        end
    end

    assign bus.tx_data          = data_reg;
    assign bus.new_tx_data      = strobe_reg;
    assign bus.tx_block_ready   = !fifo_full;
    assign bus.tx_block_busy    = !fifo_empty || (state != IDLE) || done_reg;
    assign bus.tx_block_done    = done_reg;
    assign bus.tx_block_dropped = dropped_reg;

endmodule

// File: tb/tb_mojo_serial_block_queue_out.sv
// Bench for the block serializer: two instances (LSB-first depth 2, MSB-first depth 3)
// checked each cycle against a byte-stream model plus directed literal expectations.
module tb_mojo_serial_block_queue_out;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mojo_serial_block_queue_out_if #(.BLOCK_BYTES(4)) bus0 ();
    mojo_serial_block_queue_out_if #(.BLOCK_BYTES(4)) bus1 ();

    mojo_serial_block_queue_out #(
        .BLOCK_BYTES (4),
        .QUEUE_DEPTH (2),
        .MSB_FIRST   (0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    mojo_serial_block_queue_out #(
        .BLOCK_BYTES (4),
        .QUEUE_DEPTH (3),
        .MSB_FIRST   (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // Model: expected byte stream per instance, each entry {last_of_block, byte}.
    logic [8:0] exp_mem [2][128];
    int         exp_wr [2];
    int         exp_rd [2];
    int         outstanding [2];
    bit         done_pending [2];
    bit         drop_exp [2];
    bit         busy_prev [2];
    bit         strobe_prev [2];
    int         done_cnt [2];
    int         drop_cnt [2];

    task automatic cmp(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        for (int d = 0; d < 2; d++) begin
            exp_rd[d]       = exp_wr[d];
            outstanding[d]  = 0;
            done_pending[d] = 1'b0;
            drop_exp[d]     = 1'b0;
            strobe_prev[d]  = 1'b0;
        end
    endtask

    task automatic modelPush(input int d, input logic [31:0] data, input int len, input bit msb);
        int eff;
        int idx;
        eff = (len == 0 || len > 4) ? 4 : len;
        for (int i = 0; i < eff; i++) begin
            idx = msb ? (eff - 1 - i) : i;
            exp_mem[d][exp_wr[d] % 128] = {(i == eff - 1), data[8*idx +: 8]};
            exp_wr[d]++;
        end
        outstanding[d]++;
    endtask

    // Per-cycle comparison of one instance against the model.
    task automatic checkOutput(input int d, input logic nd, input logic [7:0] data,
                               input logic done, input logic dropped, input logic busy,
                               input logic ready, input logic uart_busy);
        logic [8:0] e;
        bit         next_done;
        next_done = 1'b0;
        if (!rst_n) begin
            cmp($sformatf("dut%0d reset new_tx_data", d), nd, 0);
            cmp($sformatf("dut%0d reset busy", d), busy, 0);
            cmp($sformatf("dut%0d reset ready", d), ready, 1);
            cmp($sformatf("dut%0d reset done", d), done, 0);
            cmp($sformatf("dut%0d reset dropped", d), dropped, 0);
        end else begin
            if (nd) begin
                cmp($sformatf("dut%0d strobe while uart busy", d), busy_prev[d], 0);
                cmp($sformatf("dut%0d strobe spacing", d), strobe_prev[d], 0);
                if (exp_rd[d] == exp_wr[d]) begin
                    cmp($sformatf("dut%0d unexpected strobe", d), 1, 0);
                end else begin
                    e = exp_mem[d][exp_rd[d] % 128];
                    exp_rd[d]++;
                    cmp($sformatf("dut%0d tx_data", d), data, e[7:0]);
                    next_done = e[8];
                end
            end
            cmp($sformatf("dut%0d tx_block_done", d), done, done_pending[d]);
            cmp($sformatf("dut%0d tx_block_busy", d), busy, (outstanding[d] > 0));
            cmp($sformatf("dut%0d tx_block_dropped", d), dropped, drop_exp[d]);
            if (done) done_cnt[d]++;
            if (dropped) drop_cnt[d]++;
            if (done_pending[d] && outstanding[d] > 0) outstanding[d]--;
            done_pending[d] = next_done;
            drop_exp[d]     = 1'b0;
        end
        strobe_prev[d] = (rst_n == 1'b1) && nd;
        busy_prev[d]   = uart_busy;
    endtask

    // Compare process: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        checkOutput(0, bus0.new_tx_data, bus0.tx_data, bus0.tx_block_done, bus0.tx_block_dropped,
                    bus0.tx_block_busy, bus0.tx_block_ready, bus0.tx_busy);
        checkOutput(1, bus1.new_tx_data, bus1.tx_data, bus1.tx_block_done, bus1.tx_block_dropped,
                    bus1.tx_block_busy, bus1.tx_block_ready, bus1.tx_busy);
    end

    int last_push_cyc;

    // Push one block for one edge; the model learns of it only if it is expected to be taken.
    task automatic applyStimulus(input int d, input logic [31:0] data, input logic [2:0] len,
                                 input bit accept);
        if (d == 0) begin
            bus0.tx_block = data; bus0.tx_len = len; bus0.new_tx_block = 1'b1;
        end else begin
            bus1.tx_block = data; bus1.tx_len = len; bus1.new_tx_block = 1'b1;
        end
        @(posedge clk);
        #1;
        last_push_cyc = cyc;
        if (d == 0) bus0.new_tx_block = 1'b0;
        else        bus1.new_tx_block = 1'b0;
        if (accept) modelPush(d, data, int'(len), d == 1);
        else        drop_exp[d] = 1'b1;
    endtask

    task automatic waitStrobe(input int d, input int max_cycles, output logic [7:0] data,
                              output int at_cyc);
        bit seen;
        seen   = 1'b0;
        data   = 8'h00;
        at_cyc = -1;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(posedge clk);
            #1;
            if ((d == 0) ? bus0.new_tx_data : bus1.new_tx_data) begin
                seen   = 1'b1;
                data   = (d == 0) ? bus0.tx_data : bus1.tx_data;
                at_cyc = cyc;
            end
        end
        if (!seen) cmp($sformatf("dut%0d strobe timeout", d), 0, 1);
    endtask

    task automatic waitIdle(input int d, input int max_cycles);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max_cycles && !idle; i++) begin
            @(posedge clk);
            #1;
            idle = (outstanding[d] == 0) && (exp_rd[d] == exp_wr[d]) && !done_pending[d];
        end
        if (!idle) cmp($sformatf("dut%0d idle timeout", d), 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        int         at;
        int         d0;
        int         seen;
        int         strobes;
        int         busy_cnt;
        int         fall_cyc;
        bit         fall_valid;

        for (int d = 0; d < 2; d++) begin
            exp_wr[d] = 0; exp_rd[d] = 0; done_cnt[d] = 0; drop_cnt[d] = 0;
            busy_prev[d] = 1'b0;
        end
        modelClear();
        bus0.tx_busy = 1'b0; bus0.tx_block = '0; bus0.tx_len = '0; bus0.new_tx_block = 1'b0;
        bus1.tx_busy = 1'b0; bus1.tx_block = '0; bus1.tx_len = '0; bus1.new_tx_block = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset tx_data", bus0.tx_data, 8'h00);
        cmp("reset ready", bus0.tx_block_ready, 1);
        cmp("reset tx_data dut1", bus1.tx_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] LSB-first block, idle UART");
        d0 = done_cnt[0];
        applyStimulus(0, 32'h44332211, 3'd4, 1'b1);
        waitStrobe(0, 10, b, at);
        cmp("first strobe latency", at - last_push_cyc, 2);
        cmp("first byte", b, 8'h11);
        waitIdle(0, 40);
        cmp("done count block1", done_cnt[0] - d0, 1);
        cmp("busy after block1", bus0.tx_block_busy, 0);

        $display("[TB] MSB-first block of 3 bytes");
        d0 = done_cnt[1];
        applyStimulus(1, 32'h00CCBBAA, 3'd3, 1'b1);
        waitStrobe(1, 10, b, at);
        cmp("msb first byte", b, 8'hCC);
        waitIdle(1, 40);
        cmp("msb done count", done_cnt[1] - d0, 1);

        $display("[TB] UART busy for 10 cycles after each strobe");
        applyStimulus(0, 32'h44332211, 3'd4, 1'b1);
        strobes = 0; busy_cnt = 0; fall_cyc = 0; fall_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (bus0.new_tx_data) begin
                strobes++;
                if (fall_valid) cmp("strobe one cycle after busy falls", cyc - fall_cyc, 1);
                fall_valid   = 1'b0;
                bus0.tx_busy = 1'b1;
                busy_cnt     = 10;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus0.tx_busy = 1'b0;
                    fall_cyc     = cyc;
                    fall_valid   = 1'b1;
                end
            end
            if (strobes == 4 && busy_cnt == 0) break;
        end
        cmp("uart test strobes", strobes, 4);
        bus0.tx_busy = 1'b0;
        waitIdle(0, 20);

        $display("[TB] Overflow with UART held busy");
        bus0.tx_busy = 1'b1;
        d0 = drop_cnt[0];
        applyStimulus(0, 32'hA3A2A1A0, 3'd4, 1'b1);
        applyStimulus(0, 32'hB3B2B1B0, 3'd4, 1'b1);
        applyStimulus(0, 32'hC3C2C1C0, 3'd4, 1'b1);
        cmp("ready after third push", bus0.tx_block_ready, 0);
        applyStimulus(0, 32'hD3D2D1D0, 3'd4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cmp("dropped pulse count", drop_cnt[0] - d0, 1);
        bus0.tx_busy = 1'b0;
        waitIdle(0, 100);

        $display("[TB] Length clamping");
        d0 = done_cnt[0];
        applyStimulus(0, 32'h44332211, 3'd0, 1'b1);
        waitIdle(0, 40);
        applyStimulus(0, 32'h44332211, 3'd7, 1'b1);
        waitIdle(0, 40);
        applyStimulus(0, 32'h44332211, 3'd1, 1'b1);
        waitStrobe(0, 10, b, at);
        cmp("len1 byte", b, 8'h11);
        waitIdle(0, 40);
        cmp("len tests done count", done_cnt[0] - d0, 3);

        $display("[TB] MSB-first queue wrap, depth 3");
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1, 32'h44332211, 3'd2, 1'b1);
            applyStimulus(1, 32'h88776655, 3'd0, 1'b1);
            applyStimulus(1, 32'hCCBBAA99, 3'd1, 1'b1);
            waitIdle(1, 100);
        end

        $display("[TB] Reset in the middle of a block");
        d0 = done_cnt[0];
        applyStimulus(0, 32'h44332211, 3'd4, 1'b1);
        seen = 0;
        for (int i = 0; i < 50 && seen < 2; i++) begin
            @(posedge clk);
            #1;
            if (bus0.new_tx_data) seen++;
        end
        cmp("strobes before reset", seen, 2);
        rst_n = 1'b0;
        modelClear();
        #1;
        cmp("reset mid new_tx_data", bus0.new_tx_data, 0);
        cmp("reset mid busy", bus0.tx_block_busy, 0);
        cmp("reset mid ready", bus0.tx_block_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmp("no done from aborted block", done_cnt[0] - d0, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 32'hDDCCBBAA, 3'd4, 1'b1);
        waitStrobe(0, 10, b, at);
        cmp("first byte after reset", b, 8'hAA);
        waitIdle(0, 40);
        cmp("done after reset block", done_cnt[0] - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
